aes_key_expander: RTL

- Upstream neighbour of the encipher round datapath; produces the per-round `round_key` that the round logic consumes.
- On `init`, expands a 128- or 256-bit cipher key into 11 or 15 round keys, one round key per clock cycle.
- Stores the round keys in an internal register array with a combinational read port indexed by `round`.
- Borrows the core's shared 32-bit S-box (`sboxw` out, `new_sboxw` in) for SubWord while expanding, so it has no S-box of its own.

---
 rtl/aes_key_expander_if.sv | 37 +++
 rtl/aes_key_expander.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if
// Bundles the key expander's signals towards the cipher core.
//   key        [255:0] cipher key (128-bit mode uses key[255:128])
//   keylen             0 = AES-128, 1 = AES-256
//   init               start pulse, sampled only while the expander is idle
//   round      [3:0]   round key select for the combinational read port
//   round_key  [127:0] selected round key, {w0,w1,w2,w3}, w0 in [127:96]
//   ready              high when idle and the key array is complete
//   sboxw      [31:0]  word sent to the core's shared S-box
//   new_sboxw  [31:0]  byte-wise substitution of sboxw, same cycle
//
// Handshake: the core raises init for a cycle while ready = 1; the expander
// drops ready on the next edge and raises it again on the edge that writes
// the last round key. init seen while ready = 0 has no effect. round_key
// is only meaningful while ready = 1, and the shared S-box belongs to the
// expander exactly while ready = 0.
// master = cipher core side, slave = key expander side.
interface aes_key_expander_if;
  logic [255:0] key;
  logic         keylen;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  modport master (
    output key, keylen, init, round, new_sboxw,
    input  round_key, ready, sboxw
  );

  modport slave (
    input  key, keylen, init, round, new_sboxw,
    output round_key, ready, sboxw
  );
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander
// Expands a 128/256-bit AES cipher key into 11/15 round keys, one round key
// per clock, into a register array with a combinational read port. SubWord
// uses the core's shared S-box through bus.sboxw / bus.new_sboxw.
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   bus          aes_key_expander_if.slave (key, keylen, init, round,
//                round_key, ready, sboxw, new_sboxw)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = INIT, 2 = GENERATE)
module aes_key_expander #(
  parameter bit AES_128_BIT_KEY = 1'b0,
  parameter bit AES_256_BIT_KEY = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  aes_key_expander_if.slave        bus,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_GEN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   rk_q [15];
  logic [127:0]   rk_d [15];
  logic [3:0]     ctr_q, ctr_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           ready_q, ready_d;
  logic [255:0]   key_q, key_d;
  logic           keylen_q, keylen_d;

  logic           is256;
  logic [3:0]     last_idx;
  logic [3:0]     ctr_m1, ctr_m2;
  logic [127:0]   prev_key, prev2_key, base_key;
  logic [7:0]     rcon_step;
  logic           use_rot;
  logic [31:0]    sub_rot, t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   new_key;
  logic [127:0]   round_key_sel;

  assign is256    = (keylen_q == AES_256_BIT_KEY);
  assign last_idx = is256 ? 4'd14 : 4'd10;
  assign ctr_m1   = ctr_q - 4'd1;
  assign ctr_m2   = ctr_q - 4'd2;

  // p = rk[ctr-1], q = rk[ctr-2]; an index that wraps to 15 reads as zero.
  always_comb begin
    prev_key  = '0;
    prev2_key = '0;
    for (int i = 0; i < 15; i++) begin
      if (ctr_m1 == i[3:0]) prev_key  = rk_q[i];
      if (ctr_m2 == i[3:0]) prev2_key = rk_q[i];
    end
  end

  // rcon advances by xtime; 8'h8d is the pre-increment seed giving 8'h01.
  assign rcon_step = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // S-box input is unrotated; RotWord is applied to the substituted word,
  // which is equivalent because SubWord works byte by byte.
  assign sub_rot  = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]};
  // AES-256 odd steps take plain SubWord without rotation or rcon.
  assign use_rot  = !is256 || !ctr_q[0];
  assign t_word   = use_rot ? (sub_rot ^ {rcon_step, 24'h0}) : bus.new_sboxw;
  assign base_key = is256 ? prev2_key : prev_key;

  assign n0      = base_key[127:96] ^ t_word;
  assign n1      = base_key[95:64]  ^ n0;
  assign n2      = base_key[63:32]  ^ n1;
  assign n3      = base_key[31:0]   ^ n2;
  assign new_key = {n0, n1, n2, n3};

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    rcon_d   = rcon_q;
    ready_d  = ready_q;
    key_d    = key_q;
    keylen_d = keylen_q;
    for (int i = 0; i < 15; i++) rk_d[i] = rk_q[i];

    case (state_q)
      ST_IDLE: begin
        if (bus.init) begin
          key_d    = bus.key;
          keylen_d = bus.keylen;
          ready_d  = 1'b0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        rk_d[0] = key_q[255:128];
        rcon_d  = 8'h8d;
        if (is256) begin
          rk_d[1] = key_q[127:0];
          ctr_d   = 4'd2;
        end else begin
          ctr_d = 4'd1;
          // Entries beyond rk10 must read as zero after a 128-bit expansion.
          for (int i = 11; i < 15; i++) rk_d[i] = '0;
        end
        state_d = ST_GEN;
      end
      ST_GEN: begin
        for (int i = 0; i < 15; i++) begin
          if (ctr_q == i[3:0]) rk_d[i] = new_key;
        end
        ctr_d = ctr_q + 4'd1;
        if (use_rot) rcon_d = rcon_step;
        if (ctr_q == last_idx) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ctr_q    <= 4'd0;
      rcon_q   <= 8'h8d;
      ready_q  <= 1'b1;
      key_q    <= '0;
      keylen_q <= 1'b0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      rcon_q   <= rcon_d;
      ready_q  <= ready_d;
      key_q    <= key_d;
      keylen_q <= keylen_d;
      for (int i = 0; i < 15; i++) rk_q[i] <= rk_d[i];
    end
  end

  // Read port: round 15 has no storage; 128-bit mode hides rounds 11..14.
  always_comb begin
    round_key_sel = '0;
    for (int i = 0; i < 15; i++) begin
      if (bus.round == i[3:0]) round_key_sel = rk_q[i];
    end
    if ((keylen_q == AES_128_BIT_KEY) && (bus.round > 4'd10)) round_key_sel = '0;
  end

  assign bus.round_key = round_key_sel;
  assign bus.ready     = ready_q;
  assign bus.sboxw     = prev_key[31:0];
  assign dbg_state_o   = state_q;

endmodule
